// File: rtl/i2s_pkg.sv
// i2s_pkg: shared definitions for the I2S transmit path.
//   WS_LEFT / WS_RIGHT   : word-select encoding of the two channel slots.
//   DATA_OFFSET          : slot position of the sample MSB (1 = I2S, 0 = left-justified).
//   I2S_TX_PARAMS_OK     : parameter legality test used by the transmitter.
// Build option: define I2S_TX_LJ_EN for the left-justified format.

`define I2S_TX_PARAMS_OK(dw, sw, cd, off) (((sw) >= (dw) + (off)) && ((cd) >= 1))

package i2s_pkg;
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;
`ifdef I2S_TX_LJ_EN
  localparam int DATA_OFFSET = 0;
`else
  localparam int DATA_OFFSET = 1;
`endif
endpackage

// File: rtl/i2s_clk_div.sv
// i2s_clk_div: bit-clock generator for the I2S transmitter.
//   clk, rst_n : system clock, async active-low reset
//   en         : run enable; low clears the divider and parks bclk low next clk
//   bclk       : bit clock, half-period CLK_DIV clk
//   fall       : strobe, high in the clk whose edge takes bclk 1->0

module i2s_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bclk,
  output logic fall
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] div_cnt;
  logic          wrap;

  assign wrap = (div_cnt == CW'(CLK_DIV - 1));
  assign fall = en & wrap & bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!en) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/i2s_transmit.sv
// i2s_transmit: stereo PCM to I2S serialiser, bus master (drives BCLK/WS/SD).
//   clk, rst_n           : system clock, async active-low reset
//   en                   : transmitter enable (low = stop and clear the serial side)
//   in_left/in_right     : sample pair, in_valid/in_ready handshake into a 1-frame holding reg
//   i2s_bclk/ws/sd       : I2S bus; ws/sd update only on the BCLK falling edge
//   frame_start          : 1-clk pulse after a frame is loaded into the shifter
//   underrun             : 1-clk pulse when that load found the holding reg empty
// Build option: I2S_TX_LJ_EN selects left-justified (MSB at slot position 0).

module i2s_transmit import i2s_pkg::*; #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int CLK_DIV    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  i2s_bclk,
  output logic                  i2s_ws,
  output logic                  i2s_sd,
  output logic                  frame_start,
  output logic                  underrun
);
  localparam int  FRAME_BITS = 2 * SLOT_WIDTH;
  localparam int  BW         = $clog2(FRAME_BITS);
  localparam int  SHW        = 2 * DATA_WIDTH;
  localparam int  D_FIRST    = DATA_OFFSET;
  localparam int  D_LAST     = DATA_OFFSET + DATA_WIDTH - 1;
  localparam bit  PARAMS_OK  = `I2S_TX_PARAMS_OK(DATA_WIDTH, SLOT_WIDTH, CLK_DIV, DATA_OFFSET);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("i2s_transmit: SLOT_WIDTH too small for DATA_WIDTH, or CLK_DIV < 1");
    end
  endgenerate

  logic                  fall;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_l, hold_r;
  logic [SHW-1:0]        shifter, sh_src;
  logic [BW-1:0]         bit_cnt, nxt_cnt, pos;
  logic                  primed;
  logic                  accept, fs, in_data;
  logic                  ws_q, sd_q;
  int                    p_int;

  i2s_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .bclk (i2s_bclk),
    .fall (fall)
  );

  assign in_ready = ~hold_full;
  assign accept   = in_valid & ~hold_full;

  // 'primed' is clear after reset/enable so the first fall strobe is a frame
  // start with bit_cnt 0, instead of advancing from 0 to 1.
  always_comb begin
    fs      = fall & (~primed | (bit_cnt == BW'(FRAME_BITS - 1)));
    nxt_cnt = fs ? '0 : bit_cnt + BW'(1);
    pos     = (nxt_cnt >= BW'(SLOT_WIDTH)) ? nxt_cnt - BW'(SLOT_WIDTH) : nxt_cnt;
    p_int   = int'(pos);
    in_data = (p_int >= D_FIRST) && (p_int <= D_LAST);
    sh_src  = fs ? (hold_full ? {hold_l, hold_r} : '0) : shifter;
  end

  // Holding register: a transfer in the load clk cannot be taken by that load
  // (the load sees the register as it was), so it waits for the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
    end else begin
      if (fs)          hold_full <= accept;
      else if (accept) hold_full <= 1'b1;
      if (accept) begin
        hold_l <= in_left;
        hold_r <= in_right;
      end
    end
  end

  // Serial side; the shifter carries left then right, MSB first, so the right
  // word is at the top once the left slot's DATA_WIDTH bits have gone out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      primed      <= 1'b0;
      shifter     <= '0;
      ws_q        <= WS_LEFT;
      sd_q        <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (!en) begin
        bit_cnt <= '0;
        primed  <= 1'b0;
        shifter <= '0;
        ws_q    <= WS_LEFT;
        sd_q    <= 1'b0;
      end else if (fall) begin
        bit_cnt     <= nxt_cnt;
        primed      <= 1'b1;
        ws_q        <= (nxt_cnt >= BW'(SLOT_WIDTH)) ? WS_RIGHT : WS_LEFT;
        frame_start <= fs;
        underrun    <= fs & ~hold_full;
        if (in_data) begin
          sd_q    <= sh_src[SHW-1];
          shifter <= sh_src << 1;
        end else begin
          sd_q    <= 1'b0;
          shifter <= sh_src;
        end
      end
    end
  end

  assign i2s_ws = ws_q;
  assign i2s_sd = sd_q;
endmodule

// File: tb/tb_i2s_transmit.sv
// tb_i2s_transmit: scoreboard bench for i2s_transmit. Driver pushes accepted
// pairs (with their acceptance clk) into a queue; a monitor decodes whole
// frames on BCLK rise and compares against the expected slot images.

module tb_i2s_transmit;
  localparam int DW        = 24;
  localparam int SW        = 32;
  localparam int CD        = 4;
  localparam int FB        = 2 * SW;
  localparam int FRAME_CLK = FB * 2 * CD;

  logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_left = '0, in_right = '0;
  logic          in_ready, i2s_bclk, i2s_ws, i2s_sd, frame_start, underrun;

  i2s_transmit #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .in_ready(in_ready), .i2s_bclk(i2s_bclk), .i2s_ws(i2s_ws),
    .i2s_sd(i2s_sd), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [DW-1:0] l; logic [DW-1:0] r; int a; } pair_t;
  pair_t q[$];

  int checks = 0, errors = 0;
  int pos = 0, ur_cnt = 0, fs_cnt = 0, epoch = 0;
  bit in_frame = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // One channel slot as it should appear on the wire, first bit at the MSB.
  function automatic logic [SW-1:0] slot(input logic [DW-1:0] s);
`ifdef I2S_TX_LJ_EN
    return {s, {(SW-DW){1'b0}}};
`else
    return {1'b0, s, {(SW-DW-1){1'b0}}};
`endif
  endfunction

  // Present a pair and hold it until taken; records the clk edge of the transfer.
  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
    pair_t p;
    int n = 0;
    in_left = l; in_right = r; in_valid = 1'b1;
    while (!in_ready && n < 3 * FRAME_CLK) begin @(negedge clk); n++; end
    if (!in_ready) check_eq("send_timeout", 64'(n), 0);
    else begin
      p.l = l; p.r = r; p.a = cyc + 1;
      q.push_back(p);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2 * FRAME_CLK);
    if (!frame_start) check_eq("frame_start_timeout", 64'(n), 0);
    #1;
  endtask

  task automatic wait_pos(input int p);
    int n = 0;
    while (pos < p && n < 2 * FRAME_CLK) begin @(negedge clk); n++; end
    if (pos < p) check_eq("pos_timeout", 64'(pos), 64'(p));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 20 * FRAME_CLK) begin @(negedge clk); n++; end
    check_eq("queue_drained", 64'(q.size()), 0);
  endtask

  // Monitor / scoreboard.
  initial begin : monitor
    logic [FB-1:0] got_sd, got_ws, exp_sd;
    logic          exp_ur, prev_bclk, prev_sd, prev_ws, prev_en;
    int            last_fs_cyc, last_fs_epoch;
    pair_t         cur;
    prev_bclk = 0; prev_sd = 0; prev_ws = 0; prev_en = 0;
    last_fs_cyc = 0; last_fs_epoch = -1;
    got_sd = '0; got_ws = '0; exp_sd = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; pos = 0;
      end else begin
        if (prev_en && en && ({i2s_ws, i2s_sd} !== {prev_ws, prev_sd}) && !(prev_bclk && !i2s_bclk))
          check_eq("ws_sd_change_off_fall", {i2s_ws, i2s_sd}, {prev_ws, prev_sd});
        if (underrun && !frame_start) check_eq("underrun_without_frame_start", underrun, 0);
        if (frame_start) begin
          fs_cnt++;
          if (last_fs_epoch == epoch) check_eq("frame_period", 64'(cyc - last_fs_cyc), FRAME_CLK);
          last_fs_cyc = cyc; last_fs_epoch = epoch;
          if (q.size() > 0 && q[0].a < cyc) begin cur = q.pop_front(); exp_ur = 0; end
          else begin cur.l = '0; cur.r = '0; cur.a = 0; exp_ur = 1; end
          check_eq("underrun_flag", underrun, exp_ur);
          if (underrun) ur_cnt++;
          exp_sd = {slot(cur.l), slot(cur.r)};
          in_frame = 1; pos = 0;
        end
        if (in_frame && i2s_bclk && !prev_bclk) begin
          got_sd[FB-1-pos] = i2s_sd;
          got_ws[FB-1-pos] = i2s_ws;
          pos++;
          if (pos == FB) begin
            check_eq("frame_sd", got_sd, exp_sd);
            check_eq("frame_ws", got_ws, {{SW{1'b0}}, {SW{1'b1}}});
            in_frame = 0;
          end
        end
      end
      prev_bclk = i2s_bclk; prev_sd = i2s_sd; prev_ws = i2s_ws; prev_en = en;
    end
  end

  initial begin : main
    int n, ur0;
    repeat (3) @(negedge clk);
    check_eq("rst_bclk", i2s_bclk, 0);
    check_eq("rst_ws", i2s_ws, 0);
    check_eq("rst_sd", i2s_sd, 0);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_frame_start", frame_start, 0);
    check_eq("rst_underrun", underrun, 0);

    // Starved run: every frame underruns and carries zeros.
    rst_n = 1'b1; en = 1'b1; epoch++;
    wait_fs(n);
    check_eq("first_fs_latency", 64'(n), 64'(2 * CD));
    repeat (3 * FRAME_CLK + 100) @(negedge clk);
    check_eq("starved_all_underrun", 64'(ur_cnt), 64'(fs_cnt));
    check_eq("starved_frame_count", 64'(fs_cnt), 4);

    // Directed patterns.
    send(24'hA5A5A5, 24'h5A5A5A);
    send(24'h800001, 24'h7FFFFF);
    wait_drain();
    wait_fs(n);

    // Back-to-back with in_valid held: one pair per frame, no underrun.
    ur0 = ur_cnt;
    for (int i = 0; i < 6; i++) send(DW'($urandom), DW'($urandom));
    wait_drain();
    check_eq("b2b_no_underrun", 64'(ur_cnt), 64'(ur0));
    repeat (2) wait_fs(n);

    // Transfer in the very clk of the frame-start load.
    repeat (FRAME_CLK - 1) @(negedge clk);
    ur0 = ur_cnt;
    send(DW'($urandom), DW'($urandom));
    wait_fs(n);
    check_eq("coincident_underrun", 64'(ur_cnt), 64'(ur0 + 1));
    wait_drain();
    wait_fs(n);

    // Random gaps.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 700)) @(negedge clk);
      send(DW'($urandom), DW'($urandom));
    end
    wait_drain();
    wait_fs(n);

    // Enable dropped mid right slot; handshake while stopped; clean restart.
    wait_pos(41);
    @(negedge clk);
    check_eq("ws_high_before_stop", i2s_ws, 1);
    en = 1'b0; epoch++; ur0 = ur_cnt;
    @(negedge clk);
    check_eq("stop_bclk", i2s_bclk, 0);
    check_eq("stop_ws", i2s_ws, 0);
    check_eq("stop_sd", i2s_sd, 0);
    send(DW'($urandom), DW'($urandom));
    check_eq("stop_in_ready_low", in_ready, 0);
    repeat (20) @(negedge clk);
    check_eq("stop_bclk_idle", i2s_bclk, 0);
    en = 1'b1; epoch++;
    wait_fs(n);
    check_eq("restart_fs_latency", 64'(n), 64'(2 * CD));
    check_eq("stop_no_underrun", 64'(ur_cnt), 64'(ur0));
    wait_drain();
    repeat (2) wait_fs(n);

    // Reset in the middle of a frame with the holding register full.
    send(DW'($urandom), DW'($urandom));
    wait_pos(40);
    check_eq("pre_reset_in_ready", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_bclk", i2s_bclk, 0);
    check_eq("midrst_ws", i2s_ws, 0);
    check_eq("midrst_sd", i2s_sd, 0);
    check_eq("midrst_in_ready", in_ready, 1);
    q.delete();
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
